// File: rtl/regmask_encoder.sv
// regmask_encoder: serialises a 16-bit register mask into one 4-bit RegId per handshake.
// Optional feature macro: REGMASK_ROUND_ROBIN_EN (round-robin scan from a persistent pointer).
// Without the macro, selection is fixed priority (lowest index first).
module regmask_encoder (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_i,
    input  logic [15:0] mask_i,
    input  logic        ready_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [3:0]  reg_id_o,
    output logic [4:0]  count_o,
    output logic        done_o
);

    localparam int unsigned N_REGS  = 16;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned COUNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q;
    logic [N_REGS-1:0]    pending_q;
    logic [COUNT_W-1:0]   count_q;
    logic                 busy_q;
    logic                 valid_q;
    logic [ID_W-1:0]      reg_id_q;
    logic                 done_q;
`ifdef REGMASK_ROUND_ROBIN_EN
    logic [ID_W-1:0]      ptr_q;
`endif

    logic [N_REGS-1:0]    pending_d;
    logic [N_REGS-1:0]    src_mask;
    logic [ID_W-1:0]      src_ptr;
    logic [ID_W-1:0]      sel_id;

    // First set bit of v found scanning upward from start, wrapping 15 -> 0.
    function automatic logic [ID_W-1:0] pick_first(input logic [N_REGS-1:0] v,
                                                   input logic [ID_W-1:0] start);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] res;
        logic            found;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REGS; i++) begin
            idx = ID_W'(start + ID_W'(i));
            if (!found && v[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Number of set bits in a mask.
    function automatic logic [COUNT_W-1:0] popcount16(input logic [N_REGS-1:0] v);
        logic [COUNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_REGS; i++) begin
            cnt = cnt + COUNT_W'(v[i]);
        end
        return cnt;
    endfunction

    // Pick the id that will be presented next: from the fresh mask on load, or
    // from the remaining bits after the current handshake.
    always_comb begin
        pending_d = pending_q & ~(N_REGS'(1) << reg_id_q);
        src_mask  = mask_i;
`ifdef REGMASK_ROUND_ROBIN_EN
        src_ptr   = ptr_q;
        if (state_q == EMIT) begin
            src_ptr = ID_W'(reg_id_q + ID_W'(1));
        end
`else
        src_ptr   = '0;
`endif
        if (state_q == EMIT) begin
            src_mask = pending_d;
        end
        sel_id = pick_first(src_mask, src_ptr);
    end

    // Batch FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            reg_id_q  <= '0;
            done_q    <= 1'b0;
`ifdef REGMASK_ROUND_ROBIN_EN
            ptr_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (load_i) begin
                        pending_q <= mask_i;
                        count_q   <= popcount16(mask_i);
                        busy_q    <= 1'b1;
                        if (mask_i != '0) begin
                            valid_q  <= 1'b1;
                            reg_id_q <= sel_id;
                            state_q  <= EMIT;
                        end else begin
                            valid_q  <= 1'b0;
                            reg_id_q <= '0;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                EMIT: begin
                    if (ready_i) begin
                        pending_q <= pending_d;
                        count_q   <= count_q - COUNT_W'(1);
`ifdef REGMASK_ROUND_ROBIN_EN
                        ptr_q     <= ID_W'(reg_id_q + ID_W'(1));
`endif
                        if (pending_d == '0) begin
                            valid_q  <= 1'b0;
                            reg_id_q <= '0;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            reg_id_q <= sel_id;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign valid_o  = valid_q;
    assign reg_id_o = reg_id_q;
    assign count_o  = count_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_regmask_encoder.sv
// Testbench for regmask_encoder: cycle model comparison plus directed literal checks.
module tb_regmask_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] mask = 16'h0;
    logic        ready = 1'b0;
    logic        busy, valid, done;
    logic [3:0]  reg_id;
    logic [4:0]  count;

    int vectors = 0;
    int miscompares = 0;
    bit started = 1'b0;
    int emitted[$];

    // Model state: phase 0 idle, 1 emitting, 2 done pulse.
    int         m_phase = 0;
    logic [15:0] m_pend = 16'h0;
    int         m_ptr = 0;

    regmask_encoder dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .load_i  (load),
        .mask_i  (mask),
        .ready_i (ready),
        .busy_o  (busy),
        .valid_o (valid),
        .reg_id_o(reg_id),
        .count_o (count),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [15:0] p, input int ptr);
        for (int i = 0; i < 16; i++) begin
            if (p[(ptr + i) % 16]) return (ptr + i) % 16;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference behaviour advanced on each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_pend  = 16'h0;
            m_ptr   = 0;
            started = 1'b1;
        end else begin
            case (m_phase)
                0: if (load) begin
                    m_pend  = mask;
                    m_phase = (mask != 16'h0) ? 1 : 2;
                end
                1: if (ready) begin
                    int id;
                    id = pick(m_pend, m_ptr);
                    m_pend[id] = 1'b0;
`ifdef REGMASK_ROUND_ROBIN_EN
                    m_ptr = (id + 1) % 16;
`endif
                    if (m_pend == 16'h0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Compare DUT against the model mid-cycle and log accepted ids.
    always @(negedge clk) begin
        if (started) begin
            logic [11:0] exp_v, act_v;
            exp_v = {m_phase != 0, m_phase == 1,
                     (m_phase == 1) ? 4'(pick(m_pend, m_ptr)) : 4'h0,
                     5'($countones(m_pend)), m_phase == 2};
            act_v = {busy, valid, reg_id, count, done};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL model t=%0t: got b%0b v%0b id%0d c%0d d%0b expected b%0b v%0b id%0d c%0d d%0b",
                         $time, act_v[11], act_v[10], act_v[9:6], act_v[5:1], act_v[0],
                         exp_v[11], exp_v[10], exp_v[9:6], exp_v[5:1], exp_v[0]);
            end
            if (valid === 1'b1 && ready === 1'b1) emitted.push_back(int'(reg_id));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            cyc(1);
            n++;
        end
        chk({name, "_done_seen"}, int'(done === 1'b1), 1);
    endtask

    task automatic chk_seq(input string name, input int exp[$]);
        chk({name, "_len"}, emitted.size(), exp.size());
        for (int i = 0; i < exp.size() && i < emitted.size(); i++) begin
            chk($sformatf("%s_id%0d", name, i), emitted[i], exp[i]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_valid"}, int'(valid), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_count"}, int'(count), 0);
        chk({name, "_id"}, int'(reg_id), 0);
    endtask

    task automatic run_batch(input logic [15:0] m);
        emitted.delete();
        mask = m;
        load = 1'b1;
        ready = 1'b1;
        cyc(1);
        load = 1'b0;
        wait_done($sformatf("batch_%h", m));
        cyc(1);
    endtask

    initial begin
        int exp[$];

        // Reset state.
        cyc(2);
        chk_idle("reset");
        rst_n = 1'b1;
        cyc(1);

        // Reset mid-batch discards remaining entries.
        mask = 16'h00F0; load = 1'b1; ready = 1'b0;
        cyc(1);
        load = 1'b0;
        chk("midrst_first_id", int'(reg_id), 4);
        chk("midrst_count", int'(count), 4);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        do_reset();
        chk_idle("midrst_after");
        run_batch(16'h0001);
        exp = '{0};
        chk_seq("after_rst", exp);

        // Full mask, back to back, from a clean pointer.
        do_reset();
        emitted.delete();
        mask = 16'hFFFF; load = 1'b1; ready = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("full_count_first", int'(count), 16);
        cyc(15);
        chk("full_count_last", int'(count), 1);
        chk("full_id_last", int'(reg_id), 15);
        cyc(1);
        chk("full_done", int'(done), 1);
        chk("full_busy_in_done", int'(busy), 1);
        exp = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
        chk_seq("full", exp);
        cyc(1);
        chk("full_busy_after", int'(busy), 0);

        // Backpressure holds the presented entry.
        emitted.delete();
        mask = 16'h0204; load = 1'b1; ready = 1'b0;
        cyc(1);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_id", int'(reg_id), 2);
            chk("bp_count", int'(count), 2);
            cyc(1);
        end
        ready = 1'b1;
        wait_done("bp");
        exp = '{2, 9};
        chk_seq("bp", exp);
        cyc(1);

        // Zero mask goes straight to the done pulse.
        emitted.delete();
        mask = 16'h0000; load = 1'b1; ready = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("zero_done", int'(done), 1);
        chk("zero_valid", int'(valid), 0);
        chk("zero_busy", int'(busy), 1);
        cyc(1);
        chk("zero_done_after", int'(done), 0);
        chk("zero_busy_after", int'(busy), 0);
        chk("zero_no_emit", emitted.size(), 0);

        // Load during EMIT and DONE is ignored.
        emitted.delete();
        mask = 16'h0003; load = 1'b1; ready = 1'b1;
        cyc(1);
        mask = 16'h8000;
        cyc(2);
        chk("lwb_done", int'(done), 1);
        cyc(1);
        load = 1'b0;
        chk("lwb_idle_busy", int'(busy), 0);
        cyc(2);
        chk("lwb_not_queued", int'(busy), 0);
        exp = '{0, 1};
        chk_seq("lwb", exp);

        // Ordering depends on the selection policy.
        do_reset();
        run_batch(16'h0003);
        exp = '{0, 1};
        chk_seq("ord_a", exp);
        run_batch(16'h8001);
`ifdef REGMASK_ROUND_ROBIN_EN
        exp = '{15, 0};
`else
        exp = '{0, 15};
`endif
        chk_seq("ord_b", exp);

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regmask_encoder.md
# regmask_encoder

Sequential 16-to-4 register-mask encoder. It is the inverse of the register-file read decoder: it accepts a 16-bit register bitmask and emits the 4-bit RegId of each set bit, one per accepted handshake. It sits between a multi-register operation source (push/pop list, scoreboard flush) and the register-file port logic, and serialises a mask into single-register accesses.

## Interface
- Parameters: none. Widths are fixed at 16 entries and 4-bit ids to match the register file.
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- load  input  1  capture `mask` when `busy`=0; ignored when `busy`=1
- mask  input  16  register bitmask; bit i requests RegId i
- busy  output  1  batch in progress, from the cycle after load through the done cycle
- valid  output  1  `reg_id` holds a pending entry
- reg_id  output  4  encoded register id; 4'h0 when `valid`=0
- ready  input  1  consumer accepts `reg_id`; a handshake is `valid`&`ready` at a rising edge
- count  output  5  number of pending bits not yet handshaken (0..16)
- done  output  1  one-cycle pulse at the end of each batch

## Operation
- States: IDLE, EMIT, DONE.
- Reset (`rst_n`=0 at edge): state=IDLE; pending=0; ptr=0; all outputs 0.
  - Applies mid-batch; the remaining entries are discarded.
- IDLE:
  - `load`=1 captures `mask` into pending; `count` becomes popcount(`mask`).
  - If `mask`!=0, go to EMIT; if `mask`==0, go to DONE.
  - `load`=0 stays in IDLE.
- EMIT:
  - `valid`=1; `reg_id` = index selected from pending (see Configuration).
  - On handshake: clear pending[reg_id]; `count` decrements; ptr = reg_id+1 (mod 16).
  - If that was the last set bit, go to DONE; otherwise stay in EMIT and select the next index.
  - Without `ready`: `reg_id` and `count` hold stable; no bit is cleared.
- DONE:
  - `done`=1 and `busy`=1 for exactly one cycle, with `valid`=0 and `count`=0.
  - `load` is ignored; next state is IDLE.
- `load` asserted in EMIT or DONE has no effect and is not queued.
- `ready` while `valid`=0 has no effect.

## Timing
- Load at edge N: `busy`=1, `valid`=1 and the first `reg_id` are visible after edge N (cycle N+1). Latency is 1 cycle.
- Back-to-back: with `ready` held high, one entry per cycle, so k set bits take k cycles.
- After the final handshake at edge M: `done`=1 in cycle M+1 and `busy`=0 from cycle M+2. The next `load` is accepted at edge M+2.
- Zero mask loaded at edge N: `done` pulses in cycle N+1 and `valid` never rises.
- All outputs are registered or derived from registered state only; no combinational path from `ready` or `mask` to any output.
- `ptr` persists across batches and is cleared only by reset.

## Configuration
- Macro: `REGMASK_ROUND_ROBIN_EN`.
- Defined: selection is the first set bit of pending found by scanning upward from `ptr`, wrapping 15→0.
- Undefined: selection is the lowest-index set bit of pending (fixed priority). `ptr` logic is not built and behaves as constant 0.

## Test plan
- Reset mid-batch: load 16'h00F0, one handshake, then `rst_n`=0 for one edge → `busy`=`valid`=`done`=0, `count`=0, `reg_id`=0. A following load 16'h0001 emits 0.
- Full mask with `ready`=1: load 16'hFFFF → ids 0..15 on 16 consecutive cycles, `count` 16→1 during EMIT. `done` pulses in the following cycle.
- Backpressure: load 16'h0204 with `ready`=0 for 3 cycles → `reg_id`=2 held and `count`=2 throughout. `ready`=1 → emits 2 then 9, then `done`.
- Zero mask: load 16'h0000 → no `valid`, `done`=1 one cycle after load, `busy`=0 the cycle after.
- Load while busy: load 16'h0003, then assert `load` with 16'h8000 during EMIT and during DONE → only ids 0, 1 are emitted; 15 never appears.
- Ordering: after reset, batch 16'h0003 (emits 0, 1), then batch 16'h8001 → with `REGMASK_ROUND_ROBIN_EN`, emits 15 then 0. Without the macro, emits 0 then 15.
